switch_nport_rr: RTL and testbench

//  N-port packet switch: each input has an ingress FIFO; a round-robin arbiter

---
 rtl/switch_nport_rr.sv | 204 ++++++++++++++++++++
 tb/tb_switch_nport_rr.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_nport_rr.sv
// switch_nport_rr: N-port switch. Each input has an ingress FIFO. A round-robin arbiter
// grants one head word per cycle onto a shared bus, which multicasts it into registered output slots.
// Latency: 2 cycles from input accept to out_valid when uncontended. A head whose outputs are busy stalls only its own FIFO.

// Ingress FIFO: registered count, no write-through when full, pop ignored when empty.
// Latency 1 cycle from push to visible head; full is a pure function of registered count.
// Backpressure: the caller must gate push with !full; push while full is discarded.
module switch_nport_rr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Payload storage; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

module switch_nport_rr #(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int SRC_W      = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_dest,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS*SRC_W-1:0]      out_src,
  output logic [15:0]                     drop_cnt
);

  // Each FIFO entry carries the destination mask above the payload.
  localparam int ENT_W = NUM_PORTS + DATA_WIDTH;

  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  empty;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  free;
  logic [ENT_W-1:0]      head_ent  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] head_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  head_dest [NUM_PORTS];

  logic [SRC_W-1:0]      rr_ptr;
  logic                  gnt_vld;
  logic [SRC_W-1:0]      gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [NUM_PORTS-1:0]  gnt_dest;

  // Ingress buffering, one FIFO per input port.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    switch_nport_rr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .wdata ({in_dest[i*NUM_PORTS +: NUM_PORTS], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .pop   (pop[i]),
      .rdata (head_ent[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // in_ready depends only on registered FIFO occupancy, never on this cycle's pop.
  assign in_ready = ~full;

  // An output slot can take a new word if it is empty or is being drained this cycle.
  assign free = ~out_valid | out_ready;

  // Split head entries and form requests: a head may go only if its whole mask is free.
  always_comb begin
    push = '0;
    req  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      push[i]                    = in_valid[i] && !full[i];
      {head_dest[i], head_data[i]} = head_ent[i];
      // A zero mask trivially passes the free test, so dropped words never stall.
      req[i] = !empty[i] && ((head_dest[i] & ~free) == '0);
    end
  end

  // Round-robin search starting at rr_ptr; the first requester found wins.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    gnt_dest = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = SRC_W'(idx);
        gnt_data = head_data[idx];
        gnt_dest = head_dest[idx];
      end
    end
  end

  // Only the granted FIFO pops; this one-hot decode feeds the FIFO pop inputs.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i] = gnt_vld && (gnt_idx == SRC_W'(i));
    end
  end

  // Pointer moves past the winner so it becomes lowest priority next cycle; holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == SRC_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  // Output slots: load every masked output atomically, otherwise clear once the word is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (gnt_vld && gnt_dest[j]) begin
          out_valid[j]                          <= 1'b1;
          out_data[j*DATA_WIDTH +: DATA_WIDTH] <= gnt_data;
          out_src[j*SRC_W +: SRC_W]            <= gnt_idx;
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

  // Count granted zero-mask words, saturating rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (gnt_vld && (gnt_dest == '0) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_switch_nport_rr.sv
// Bench for switch_nport_rr: directed scenarios plus random traffic.
// Expected words are queued per (output, source) pair at ingress; a monitor pops them at egress.
// Words from one source to one output must arrive in acceptance order; arbitration interleaving is free.
module tb_switch_nport_rr;
  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int SW    = 2;
  localparam int DESTW = NP * NP;
  localparam int DATAW = NP * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_ready;
  logic [DATAW-1:0] in_data;
  logic [DESTW-1:0] in_dest;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_ready;
  logic [DATAW-1:0] out_data;
  logic [NP*SW-1:0] out_src;
  logic [15:0]      drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: expected payloads per (output*NP + source), and pending drop count.
  logic [DW-1:0] exp_q [NP*NP][$];
  int            exp_drops = 0;
  bit            rec_en = 1'b0;
  int            rec_q [$];
  bit            prev_hold [NP];
  logic [DW-1:0] prev_data [NP];
  logic [SW-1:0] prev_src  [NP];

  switch_nport_rr #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    for (int k = 0; k < NP*NP; k++) exp_q[k].delete();
    exp_drops = 0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NP*NP; k++) s += exp_q[k].size();
    return s;
  endfunction

  // Ingress capture and egress scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NP-1:0] d;
    logic [DW-1:0] e;
    int            s;
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          d = in_dest[i*NP +: NP];
          if (d == '0) exp_drops++;
          for (int j = 0; j < NP; j++)
            if (d[j]) exp_q[j*NP+i].push_back(in_data[i*DW +: DW]);
        end
      end
      for (int j = 0; j < NP; j++) begin
        if (prev_hold[j]) begin
          checks++;
          if (!out_valid[j] || out_data[j*DW +: DW] !== prev_data[j] || out_src[j*SW +: SW] !== prev_src[j]) begin
            errors++;
            $display("FAIL hold_port%0d: got v=%0b d=%0h s=%0d required v=1 d=%0h s=%0d", j,
                     out_valid[j], out_data[j*DW +: DW], out_src[j*SW +: SW], prev_data[j], prev_src[j]);
          end
        end
        if (out_valid[j] && out_ready[j]) begin
          s = int'(out_src[j*SW +: SW]);
          if (rec_en && j == 0) rec_q.push_back(s);
          checks++;
          if (exp_q[j*NP+s].size() == 0) begin
            errors++;
            $display("FAIL egress_port%0d: got unexpected word %0h src %0d, required none", j, out_data[j*DW +: DW], s);
          end else begin
            e = exp_q[j*NP+s].pop_front();
            if (out_data[j*DW +: DW] !== e) begin
              errors++;
              $display("FAIL egress_port%0d src%0d: got %0h required %0h", j, s, out_data[j*DW +: DW], e);
            end
          end
        end
        prev_hold[j] = out_valid[j] && !out_ready[j];
        prev_data[j] = out_data[j*DW +: DW];
        prev_src[j]  = out_src[j*SW +: SW];
      end
    end else begin
      for (int j = 0; j < NP; j++) prev_hold[j] = 1'b0;
    end
  end

  // Drive n words from port p with mask d, one attempt per cycle, bounded.
  task automatic send(input int p, input int n, input logic [NP-1:0] d, input int bound);
    int acc = 0;
    int cyc = 0;
    in_dest[p*NP +: NP] = d;
    in_data[p*DW +: DW] = DW'($urandom);
    in_valid[p] = 1'b1;
    while (acc < n && cyc < bound) begin
      @(negedge clk);
      if (in_ready[p]) acc++;
      tick();
      cyc++;
      in_data[p*DW +: DW] = DW'($urandom);
      if (acc >= n) in_valid[p] = 1'b0;
    end
    in_valid[p] = 1'b0;
    check($sformatf("send_p%0d_accepted", p), acc, n);
  endtask

  task automatic wait_drained(input string name, input int bound);
    int c = 0;
    while (pending() != 0 && c < bound) begin
      tick();
      c++;
    end
    check(name, pending(), 0);
  endtask

  int cnt_src [NP];
  int bad_order;

  initial begin
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_dest = '0; out_ready = '1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    tick(); rst = 1'b0; tick();

    // Unicast with two-cycle latency.
    in_data[1*DW +: DW] = 8'hA5; in_dest[1*NP +: NP] = 4'b0100; in_valid = 4'b0010;
    tick(); in_valid = '0;
    tick();
    check("uni_out_valid", out_valid, 4'b0100);
    check("uni_out_data", out_data[2*DW +: DW], 8'hA5);
    check("uni_out_src", out_src[2*SW +: SW], 1);
    repeat (3) tick();

    // Multicast lands on all masked outputs in the same cycle.
    in_data[0 +: DW] = 8'h3C; in_dest[0 +: NP] = 4'b1011; in_valid = 4'b0001;
    tick(); in_valid = '0;
    tick();
    check("mc_out_valid", out_valid, 4'b1011);
    for (int j = 0; j < NP; j++) begin
      if (j != 2) begin
        check($sformatf("mc_data_p%0d", j), out_data[j*DW +: DW], 8'h3C);
        check($sformatf("mc_src_p%0d", j), out_src[j*SW +: SW], 0);
      end
    end
    repeat (3) tick();

    // Fairness: all inputs stream to output 0.
    for (int i = 0; i < NP; i++) in_dest[i*NP +: NP] = 4'b0001;
    in_valid = '1;
    for (int c = 0; c < 100 && rec_q.size() < 16; c++) begin
      in_data = DATAW'($urandom);
      if (c == 4) rec_en = 1'b1;
      tick();
    end
    rec_en = 1'b0; in_valid = '0;
    check("fair_samples", rec_q.size() >= 16, 1);
    bad_order = 0;
    for (int i = 0; i < NP; i++) cnt_src[i] = 0;
    for (int k = 0; k < rec_q.size() && k < 16; k++) begin
      cnt_src[rec_q[k]]++;
      if (k > 0 && rec_q[k] != (rec_q[k-1] + 1) % NP) bad_order++;
    end
    check("fair_rr_order", bad_order, 0);
    for (int i = 0; i < NP; i++) check($sformatf("fair_share_p%0d", i), cnt_src[i], 4);
    wait_drained("fair_drain", 50);

    // Backpressure on output 3 blocks only input 2.
    out_ready = 4'b0111;
    send(2, 5, 4'b1000, 40);
    tick(); tick();
    check("bp_in_ready2", in_ready[2], 0);
    check("bp_out_valid3", out_valid[3], 1);
    send(0, 3, 4'b0010, 40);
    repeat (4) tick();
    check("bp_other_flows", exp_q[1*NP+0].size(), 0);
    check("bp_still_blocked", in_ready[2], 0);
    out_ready = '1;
    wait_drained("bp_drain", 50);

    // Zero-mask drops.
    send(3, 3, 4'b0000, 40);
    repeat (5) tick();
    check("drop_three", drop_cnt, 3);
    check("drop_no_output", out_valid, 0);

    // Random traffic with random output readiness.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = NP'($urandom);
      in_data   = DATAW'($urandom);
      in_dest   = DESTW'($urandom);
      out_ready = NP'($urandom_range(0, 15) | $urandom_range(0, 15));
      tick();
    end
    in_valid = '0; out_ready = '1;
    wait_drained("rand_drain", 100);
    repeat (3) tick();
    check("rand_drop_cnt", drop_cnt, exp_drops);

    // Drop counter saturation.
    if (exp_drops < 16'hFFFE) send(3, 16'hFFFE - exp_drops, 4'b0000, 70000);
    repeat (5) tick();
    check("drop_fffe", drop_cnt, 16'hFFFE);
    send(3, 2, 4'b0000, 40);
    repeat (5) tick();
    check("drop_sat_ffff", drop_cnt, 16'hFFFF);
    send(3, 1, 4'b0000, 40);
    repeat (5) tick();
    check("drop_stays_ffff", drop_cnt, 16'hFFFF);

    // Reset with full FIFOs and valid, stalled outputs.
    out_ready = '0;
    for (int i = 0; i < NP; i++) in_dest[i*NP +: NP] = NP'(1 << i);
    in_valid = '1;
    repeat (12) tick();
    in_valid = '0;
    check("pre_rst_busy", out_valid, 4'hF);
    check("pre_rst_full", in_ready, 0);
    #1;
    rst = 1'b1;
    flush_model();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 4'hF);
    check("midrst_drop_cnt", drop_cnt, 0);
    tick(); rst = 1'b0; out_ready = '1; tick();
    in_data[2*DW +: DW] = 8'h5A; in_dest[2*NP +: NP] = 4'b0001; in_valid = 4'b0100;
    tick(); in_valid = '0;
    tick();
    check("postrst_out_valid", out_valid, 4'b0001);
    check("postrst_out_data", out_data[0 +: DW], 8'h5A);
    check("postrst_out_src", out_src[0 +: SW], 2);
    wait_drained("final_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
